tt_um_unload: RTL and testbench

Weight read-back transmitter for the ternary matrix engine. It serializes a loaded weight array into the same two-beat-per-column protocol the weight loader accepts: an MSB-plane beat, then an LSB-plane beat, for each output column. It sits between the weight store and the host-facing output pins. Its stream can be looped directly into the weight loader to copy or verify a matrix.

---
 rtl/tt_um_unload.sv | 122 ++++++++++++
 tb/tb_tt_um_unload.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_unload.sv
`default_nettype none
// ============================================================================
// tt_um_unload : serializes a ternary weight array as MSB/LSB beat pairs.
// Rev 1.0
// ============================================================================
module tt_um_unload #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               ready,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  input  logic [6:0]                         ui_param,
  output logic [MAX_IN_LEN-1:0]              uo_data,
  output logic                               uo_valid,
  output logic                               uo_phase,
  output logic                               uo_last,
  output logic                               uo_busy,
  output logic                               uo_done
);

  localparam int COL_W  = $clog2(MAX_OUT_LEN);
  localparam int LANE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_MSB = 2'd1,
    SEND_LSB = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [COL_W-1:0]    last_col_q, last_col_d;
  logic [LANE_W-1:0]   last_in_q, last_in_d;
  logic                done_q, done_d;

  logic                is_lsb;
  logic                is_last;
  logic [MAX_IN_LEN-1:0] lane_bits;
  logic [MAX_IN_LEN-1:0] lane_mask;

  assign is_lsb  = (state_q == SEND_LSB);
  assign is_last = is_lsb && (col_q == last_col_q);

  // Each lane owns a contiguous 2*MAX_OUT_LEN slice; {col, ~lsb} selects the plane bit.
  for (genvar i = 0; i < MAX_IN_LEN; i++) begin : g_lane
    logic [2*MAX_OUT_LEN-1:0] lane_w;
    assign lane_w       = ui_weights[2*MAX_OUT_LEN*i +: 2*MAX_OUT_LEN];
    assign lane_bits[i] = lane_w[{col_q, ~is_lsb}];
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < MAX_IN_LEN; i++) begin
      if (i <= int'(last_in_q)) lane_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    last_col_d = last_col_q;
    last_in_d  = last_in_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          last_col_d = ui_param[COL_W-1:0];
          last_in_d  = ui_param[6:3];
          col_d      = '0;
          state_d    = SEND_MSB;
        end
      end
      SEND_MSB: begin
        if (ready) state_d = SEND_LSB;
      end
      SEND_LSB: begin
        if (ready) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            col_d   = '0;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = SEND_MSB;
          end
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      last_col_q <= '0;
      last_in_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      last_col_q <= last_col_d;
      last_in_q  <= last_in_d;
      done_q     <= done_d;
    end
  end

  assign uo_busy  = (state_q != IDLE);
  assign uo_valid = uo_busy;
  assign uo_phase = is_lsb;
  assign uo_last  = is_last;
  assign uo_done  = done_q;
  assign uo_data  = uo_valid ? (lane_bits & lane_mask) : '0;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_unload.sv
`default_nettype none
// ============================================================================
// tb_tt_um_unload : scoreboard bench for the weight read-back transmitter.
// Rev 1.0
// ============================================================================
module tb_tt_um_unload;

  localparam int NL = 16;
  localparam int NC = 8;
  localparam int WW = 2*NL*NC;

  typedef struct packed {
    logic          phase;
    logic          last;
    logic [NL-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ready;
  logic [WW-1:0] ui_weights;
  logic [6:0]    ui_param;
  logic [NL-1:0] uo_data;
  logic          uo_valid, uo_phase, uo_last, uo_busy, uo_done;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t exp_q[$];

  tt_um_unload #(.MAX_IN_LEN(NL), .MAX_OUT_LEN(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .ui_weights(ui_weights), .ui_param(ui_param),
    .uo_data(uo_data), .uo_valid(uo_valid), .uo_phase(uo_phase),
    .uo_last(uo_last), .uo_busy(uo_busy), .uo_done(uo_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weights a loader would hold after receiving this stream: lanes/columns past the dimensions are zero.
  function automatic logic [WW-1:0] masked(input logic [WW-1:0] w, input logic [6:0] p);
    logic [WW-1:0] m = '0;
    for (int i = 0; i < NL; i++)
      for (int c = 0; c < NC; c++)
        if (i <= int'(p[6:3]) && c <= int'(p[2:0])) begin
          m[2*(i*NC+c)+1] = w[2*(i*NC+c)+1];
          m[2*(i*NC+c)]   = w[2*(i*NC+c)];
        end
    return m;
  endfunction

  task automatic push_expected(input logic [6:0] p);
    beat_t b;
    for (int c = 0; c <= int'(p[2:0]); c++)
      for (int ph = 0; ph < 2; ph++) begin
        b.phase = ph[0];
        b.last  = (ph == 1) && (c == int'(p[2:0]));
        b.data  = '0;
        for (int i = 0; i <= int'(p[6:3]); i++)
          b.data[i] = ui_weights[2*(i*NC+c) + (ph == 0 ? 1 : 0)];
        exp_q.push_back(b);
      end
  endtask

  // Entered and left at posedge+1. With hold_start the task returns in the done cycle
  // with start still high; the next call then uses skip_start to follow the chained run.
  task automatic run_stream(input logic [6:0] p, input bit rand_ready, input bit hold_start,
                            input bit skip_start, input bit pulse_mid);
    beat_t         e;
    int            cycles = 0;
    int            nbeat  = 0;
    bit            prev_stall = 0;
    logic [NL-1:0] prev_data = '0;
    logic          prev_phase = 0;
    logic [WW-1:0] recon = '0;
    exp_q.delete();
    push_expected(p);
    if (!skip_start) begin
      ui_param = p;
      start    = 1'b1;
    end
    step();
    if (!hold_start) start = 1'b0;
    check("start_latency_valid", WW'(uo_valid), WW'(1));
    ui_param = p ^ 7'h2A;
    while (exp_q.size() > 0 && cycles < 400) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse_mid && cycles == 3) start = 1'b1;
      else if (!hold_start) start = 1'b0;
      if (prev_stall) begin
        check("stall_data_hold", WW'(uo_data), WW'(prev_data));
        check("stall_phase_hold", WW'(uo_phase), WW'(prev_phase));
      end
      check("busy_in_run", WW'({uo_valid, uo_busy}), WW'(2'b11));
      if (ready) begin
        e = exp_q.pop_front();
        check("beat_data", WW'(uo_data), WW'(e.data));
        check("beat_phase", WW'(uo_phase), WW'(e.phase));
        check("beat_last", WW'(uo_last), WW'(e.last));
        for (int i = 0; i < NL; i++)
          recon[2*(i*NC + nbeat/2) + (uo_phase ? 0 : 1)] = uo_data[i];
        nbeat++;
      end
      prev_stall = !ready;
      prev_data  = uo_data;
      prev_phase = uo_phase;
      step();
      cycles++;
    end
    check("stream_timeout", WW'(exp_q.size()), WW'(0));
    if (!rand_ready) check("throughput_cycles", WW'(cycles), WW'(2*(int'(p[2:0])+1)));
    check("done_cycle", WW'({uo_done, uo_busy, uo_valid}), WW'(3'b100));
    check("loopback_weights", recon, masked(ui_weights, p));
    if (!hold_start) begin
      step();
      check("done_one_cycle", WW'(uo_done), WW'(0));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    ready      = 1'b1;
    ui_param   = '0;
    for (int k = 0; k < WW/32; k++) ui_weights[32*k +: 32] = $urandom();
    #3;
    check("reset_outputs", WW'({uo_valid, uo_phase, uo_last, uo_busy, uo_done, uo_data}), WW'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full size, then partial dimensions with a mid-run parameter change.
    run_stream(7'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_stream({4'd5, 3'd2}, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-pressure on a new weight set, full and partial.
    for (int k = 0; k < WW/32; k++) ui_weights[32*k +: 32] = $urandom();
    run_stream(7'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream({4'd9, 3'd4}, 1'b1, 1'b0, 1'b0, 1'b0);

    // Start held through a run chains a second run from the done cycle.
    run_stream({4'd3, 3'd1}, 1'b0, 1'b1, 1'b0, 1'b0);
    run_stream({4'd3, 3'd1} ^ 7'h2A, 1'b0, 1'b0, 1'b1, 1'b0);

    // Start pulsed mid-run is ignored; single-column boundary too.
    run_stream({4'd15, 3'd5}, 1'b0, 1'b0, 1'b0, 1'b1);
    run_stream({4'd0, 3'd0}, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during the LSB beat of column 3.
    ui_param = 7'h7F;
    start    = 1'b1;
    ready    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check("pre_reset_lsb_col3", WW'({uo_valid, uo_phase, uo_last}), WW'(3'b110));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", WW'({uo_valid, uo_phase, uo_last, uo_busy, uo_done, uo_data}), WW'(0));
    step();
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("no_done_after_abort", WW'({uo_done, uo_busy}), WW'(0));
    run_stream(7'h7F, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
